dma_2d_write_master: RTL

AXI4 write master that sits directly downstream of the 2D read master's data FIFO. It pops 32-bit words from that FIFO and writes them as a 2D rectangle to destination memory: one line of i_img_width bytes, then a jump of i_img_stride bytes, repeated for i_img_height lines. Bursts never exceed 256 bytes, never run past the end of a line, and never cross a 4 KB boundary. One write transaction is outstanding at a time; the block waits for BRESP before issuing the next AW.

---
 rtl/dma_2d_pkg.sv | 22 ++
 rtl/dma_burst_calc.sv | 22 ++
 rtl/dma_2d_write_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dma_2d_pkg.sv
// Shared types and constants for the 2D DMA read/write masters.
package dma_2d_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_ADDR = 4'b0010,
      ST_DATA = 4'b0100,
      ST_RESP = 4'b1000
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   localparam int unsigned MAX_BURST_BYTES = 256;
   localparam int unsigned PAGE_BYTES      = 4096;

   function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min(256 bytes, bytes left in the line, bytes left in the 4 KB page).
module dma_burst_calc
   import dma_2d_pkg::*;
(
   input  logic [31:0] width_i,
   input  logic [31:0] line_bytes_i,
   input  logic [11:0] page_off_i,
   output logic [31:0] burst_bytes_o,
   output logic [7:0]  burst_len_o
);

   logic [31:0] line_rem;
   logic [31:0] page_rem;

   always_comb begin
      line_rem      = width_i - line_bytes_i;
      page_rem      = 32'(PAGE_BYTES) - {20'd0, page_off_i};
      burst_bytes_o = min_u32(min_u32(32'(MAX_BURST_BYTES), line_rem), page_rem);
      burst_len_o   = 8'((burst_bytes_o >> 2) - 32'd1);
   end

endmodule

// File: rtl/dma_2d_write_master.sv
// AXI4 write master draining a FWFT FIFO into a 2D destination rectangle,
// one outstanding burst at a time.
module dma_2d_write_master
   import dma_2d_pkg::*;
#(
   parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_start,
   input  logic [31:0]                   i_dst_addr,
   input  logic [31:0]                   i_img_width,
   input  logic [31:0]                   i_img_height,
   input  logic [31:0]                   i_img_stride,
   output logic                          o_write_done,
   output logic                          o_write_error,
   input  logic                          i_fifo_empty,
   input  logic [31:0]                   i_fifo_data,
   output logic                          o_fifo_pop,
   output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_awid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
   output logic [3:0]                    m_axi_wstrb,
   output logic                          m_axi_wlast,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready
);

   state_e      state_q, state_d;
   logic [31:0] width_q, width_d;
   logic [31:0] height_q, height_d;
   logic [31:0] stride_q, stride_d;
   logic [31:0] cur_addr_q, cur_addr_d;
   logic [31:0] line_start_q, line_start_d;
   logic [31:0] line_bytes_q, line_bytes_d;
   logic [31:0] line_cnt_q, line_cnt_d;
   logic [8:0]  beats_q, beats_d;
   logic [8:0]  beat_cnt_q, beat_cnt_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   logic [31:0] burst_bytes_c;
   logic [7:0]  burst_len_c;
   logic        wvalid_c;
   logic        wlast_c;
   logic        w_hs_c;
   logic        line_end_c;

   dma_burst_calc u_burst_calc (
      .width_i       (width_q),
      .line_bytes_i  (line_bytes_q),
      .page_off_i    (cur_addr_q[11:0]),
      .burst_bytes_o (burst_bytes_c),
      .burst_len_o   (burst_len_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         width_q      <= '0;
         height_q     <= '0;
         stride_q     <= '0;
         cur_addr_q   <= '0;
         line_start_q <= '0;
         line_bytes_q <= '0;
         line_cnt_q   <= '0;
         beats_q      <= '0;
         beat_cnt_q   <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         width_q      <= width_d;
         height_q     <= height_d;
         stride_q     <= stride_d;
         cur_addr_q   <= cur_addr_d;
         line_start_q <= line_start_d;
         line_bytes_q <= line_bytes_d;
         line_cnt_q   <= line_cnt_d;
         beats_q      <= beats_d;
         beat_cnt_q   <= beat_cnt_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d      = state_q;
      width_d      = width_q;
      height_d     = height_q;
      stride_d     = stride_q;
      cur_addr_d   = cur_addr_q;
      line_start_d = line_start_q;
      line_bytes_d = line_bytes_q;
      line_cnt_d   = line_cnt_q;
      beats_d      = beats_q;
      beat_cnt_d   = beat_cnt_q;
      done_d       = done_q;
      error_d      = error_q;

      wvalid_c   = (state_q == ST_DATA) && !i_fifo_empty;
      wlast_c    = wvalid_c && (beat_cnt_q == (beats_q - 9'd1));
      w_hs_c     = wvalid_c && m_axi_wready;
      line_end_c = (line_bytes_q + burst_bytes_c) >= width_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               width_d      = i_img_width;
               height_d     = i_img_height;
               stride_d     = i_img_stride;
               cur_addr_d   = i_dst_addr;
               line_start_d = i_dst_addr;
               line_bytes_d = '0;
               line_cnt_d   = '0;
               error_d      = 1'b0;
               if ((i_img_width == 32'd0) || (i_img_height == 32'd0)) begin
                  done_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  state_d = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (m_axi_awready) begin
               beats_d    = 9'(burst_bytes_c >> 2);
               beat_cnt_d = '0;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs_c) begin
               beat_cnt_d = beat_cnt_q + 9'd1;
               if (wlast_c) state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != RESP_OKAY) error_d = 1'b1;
               // Line finished: hop to the next line start (stride may wrap negative).
               if (line_end_c) begin
                  line_start_d = line_start_q + stride_q;
                  cur_addr_d   = line_start_q + stride_q;
                  line_bytes_d = '0;
                  line_cnt_d   = line_cnt_q + 32'd1;
               end else begin
                  cur_addr_d   = cur_addr_q + burst_bytes_c;
                  line_bytes_d = line_bytes_q + burst_bytes_c;
               end
               if (line_end_c && (line_cnt_q == (height_q - 32'd1))) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ADDR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_write_done  = done_q;
   assign o_write_error = error_q;
   assign o_fifo_pop    = w_hs_c;

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = C_M_AXI_ADDR_WIDTH'(cur_addr_q);
   assign m_axi_awlen   = burst_len_c;
   assign m_axi_awsize  = SIZE_4B;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awvalid = (state_q == ST_ADDR);
   assign m_axi_wdata   = C_M_AXI_DATA_WIDTH'(i_fifo_data);
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_wlast   = wlast_c;
   assign m_axi_wvalid  = wvalid_c;
   assign m_axi_bready  = (state_q == ST_RESP);

endmodule
